// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ byte requesters. Arbitration is
//   round-robin. A launch registers the winner's byte onto tx_data and pulses
//   tx_start together with a one-hot grant. The FSM then waits for the
//   transmitter to report busy, and then for it to go idle again. If busy
//   never rises within START_TIMEOUT cycles, timeout_err pulses and the FSM
//   returns to idle.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req          per-requester request bits
//   req_data     packed request bytes, requester i at [8i+7:8i]
//   grant        one-hot, single-cycle acceptance pulse
//   tx_data      byte presented to the transmitter
//   tx_start     single-cycle start pulse, coincident with grant
//   tx_busy      busy flag from the transmitter
//   active_id    requester owning the current or last transfer
//   idle         high while the FSM is in IDLE
//   timeout_err  single-cycle pulse when tx_busy never rose after a launch
module uart_tx_arbiter #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           grant,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(N_REQ)-1:0]   active_id,
    output logic                       idle,
    output logic                       timeout_err
);

    localparam int unsigned PTR_W       = $clog2(N_REQ);
    localparam logic [3:0]  TIMEOUT_CNT = 4'(START_TIMEOUT);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_START_WAIT = 2'd1;
    localparam logic [1:0] S_BUSY       = 2'd2;

    logic [1:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [3:0]       cnt;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] idx;
    logic [N_REQ-1:0] win_onehot;
    logic [7:0]       win_data;

    // Scan the requesters starting at ptr. The index wraps by truncation,
    // because N_REQ is a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ptr + PTR_W'(k);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        win_onehot          = '0;
        win_onehot[win_idx] = win_found;
        win_data            = req_data[{win_idx, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            grant       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            active_id   <= '0;
            idle        <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            grant       <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A frame still in flight (for example after a reset)
                    // blocks the launch.
                    if (!tx_busy && win_found) begin
                        state     <= S_START_WAIT;
                        idle      <= 1'b0;
                        grant     <= win_onehot;
                        tx_start  <= 1'b1;
                        tx_data   <= win_data;
                        active_id <= win_idx;
                        ptr       <= win_idx + 1'b1;
                        cnt       <= '0;
                    end
                end
                S_START_WAIT: begin
                    if (tx_busy) begin
                        state <= S_BUSY;
                        cnt   <= '0;
                    end else if (cnt + 1'b1 == TIMEOUT_CNT) begin
                        state       <= S_IDLE;
                        idle        <= 1'b1;
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BUSY: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                        idle  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter.
// A behavioural UART transmitter/receiver pair (100 clocks per bit) sits on
// the arbiter outputs. Every cycle, the outputs are compared against a
// transfer-level reference model.
module tb_uart_tx_arbiter;

    localparam int TMO = 8;
    localparam int CPB = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  active_id;
    logic        idle;
    logic        timeout_err;

    logic use_uart   = 1'b1;
    logic busy_force = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .active_id(active_id), .idle(idle),
        .timeout_err(timeout_err)
    );

    // ---------------- behavioural UART tx ----------------
    logic       u_busy  = 1'b0;
    logic       u_line  = 1'b1;
    logic [9:0] u_sh    = '0;
    int         u_bits  = 0;
    int         u_ticks = 0;

    assign tx_busy = use_uart ? u_busy : busy_force;

    always @(posedge clk) begin
        if (!u_busy) begin
            if (tx_start && use_uart) begin
                u_busy  <= 1'b1;
                u_sh    <= {1'b1, tx_data, 1'b0};
                u_line  <= 1'b0;
                u_bits  <= 0;
                u_ticks <= 0;
            end
        end else if (u_ticks == CPB - 1) begin
            u_ticks <= 0;
            if (u_bits == 9) begin
                u_busy <= 1'b0;
                u_line <= 1'b1;
            end else begin
                u_bits <= u_bits + 1;
                u_line <= u_sh[u_bits + 1];
            end
        end else begin
            u_ticks <= u_ticks + 1;
        end
    end

    // ---------------- behavioural UART rx ----------------
    logic       r_act    = 1'b0;
    logic       r_prev   = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] r_sh     = '0;
    logic [7:0] rx_data  = '0;
    int         r_ticks  = 0;
    int         r_bits   = 0;
    logic [7:0] rx_q[$];

    always @(posedge clk) begin
        rx_valid <= 1'b0;
        r_prev   <= u_line;
        if (!r_act) begin
            if (r_prev && !u_line) begin
                r_act   <= 1'b1;
                r_ticks <= 1;
                r_bits  <= 0;
            end
        end else begin
            r_ticks <= r_ticks + 1;
            if (r_ticks == CPB / 2 + CPB * (r_bits + 1)) begin
                if (r_bits < 8) begin
                    r_sh[r_bits] <= u_line;
                    r_bits       <= r_bits + 1;
                end else begin
                    r_act <= 1'b0;
                    if (u_line) begin
                        rx_valid <= 1'b1;
                        rx_data  <= r_sh;
                        rx_q.push_back(r_sh);
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Transfer-level view: a transfer is open from launch until the
    // transmitter reports busy and then goes quiet, or until the start wait
    // runs out.
    logic       m_xfer;
    logic       m_seen_busy;
    int         m_wait;
    int         m_ptr;
    logic [3:0] e_grant;
    logic       e_start;
    logic [7:0] e_data;
    logic [1:0] e_id;
    logic       e_idle;
    logic       e_tmo;
    logic       last_b;
    int         rxv_cnt = 0;

    function automatic int rr_pick(input logic [3:0] rq, input int p);
        for (int d = 0; d < 4; d++)
            if (rq[(p + d) % 4]) return (p + d) % 4;
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] rq,
                              input logic [31:0] rd, input logic b);
        int w;
        e_grant = '0;
        e_start = 1'b0;
        e_tmo   = 1'b0;
        if (r) begin
            m_xfer = 1'b0; m_seen_busy = 1'b0; m_wait = 0; m_ptr = 0;
            e_data = '0; e_id = '0; e_idle = 1'b1;
            return;
        end
        if (!m_xfer) begin
            w = rr_pick(rq, m_ptr);
            if (!b && w >= 0) begin
                e_grant     = 4'(1 << w);
                e_start     = 1'b1;
                e_data      = rd[8*w +: 8];
                e_id        = 2'(w);
                m_ptr       = (w + 1) % 4;
                m_xfer      = 1'b1;
                m_seen_busy = 1'b0;
                m_wait      = 0;
            end
        end else if (!m_seen_busy) begin
            if (b) m_seen_busy = 1'b1;
            else begin
                m_wait++;
                if (m_wait == TMO) begin
                    e_tmo  = 1'b1;
                    m_xfer = 1'b0;
                end
            end
        end else if (!b) begin
            m_xfer = 1'b0;
        end
        e_idle = !m_xfer;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock: snapshot inputs, advance the model at the edge, compare at negedge.
    task automatic step();
        logic r, b;
        logic [3:0]  q;
        logic [31:0] d;
        r = rst; q = req; d = req_data;
        b = use_uart ? u_busy : busy_force;
        last_b = b;
        @(posedge clk);
        model_step(r, q, d, b);
        @(negedge clk);
        if (rx_valid) rxv_cnt++;
        check("grant",       grant,       e_grant);
        check("tx_start",    tx_start,    e_start);
        check("tx_data",     tx_data,     e_data);
        check("active_id",   active_id,   e_id);
        check("idle",        idle,        e_idle);
        check("timeout_err", timeout_err, e_tmo);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag, input int bound, input logic drop,
                              output logic [3:0] g);
        logic seen = 1'b0;
        g = '0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            if (grant != 0) begin
                seen = 1'b1;
                g    = grant;
                if (drop) req = req & ~grant;
            end
        end
        check({tag, "_grant_seen"}, seen, 1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        logic seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            if (idle && !(use_uart && u_busy)) seen = 1'b1;
        end
        check({tag, "_idle_seen"}, seen, 1);
    endtask

    initial begin
        logic [3:0] g;
        logic [7:0] exp_bytes [5];
        int         exp_order [5];
        int         order[$];
        int         n;
        logic       seen;

        rst = 1'b1; req = '0; req_data = '0;
        @(negedge clk);

        // Reset values
        do_reset(3);
        check("rst_grant", grant, 0);
        check("rst_idle",  idle,  1);
        check("rst_data",  tx_data, 0);

        // Single request through the UART pair
        rx_q.delete(); rxv_cnt = 0;
        req = 4'b0001; req_data = 32'h0000_00AA;
        wait_grant("single", 10, 1'b1, g);
        check("single_grant", g, 4'b0001);
        step();
        check("single_grant_1cyc", grant, 0);
        wait_idle("single", 1200);
        repeat (3) step();
        check("single_rx_cnt",   rx_q.size(), 1);
        check("single_rxv_cnt",  rxv_cnt, 1);
        if (rx_q.size() > 0) check("single_rx_byte", rx_q[0], 8'hAA);
        check("single_idle", idle, 1);

        // All-request fairness
        do_reset(2);
        rx_q.delete();
        exp_order = '{0, 1, 2, 3, 0};
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        req = 4'b1111; req_data = 32'h4433_2211;
        for (int i = 0; i < 6000 && order.size() < 5; i++) begin
            step();
            for (int k = 0; k < 4; k++) if (grant[k]) order.push_back(k);
        end
        req = '0;
        wait_idle("fair", 1200);
        repeat (3) step();
        check("fair_grant_cnt", order.size(), 5);
        check("fair_rx_cnt", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) check("fair_order", order[i], exp_order[i]);
            if (i < rx_q.size())  check("fair_rx_byte", rx_q[i], exp_bytes[i]);
        end

        // Pointer rotation, transmitter silent so each launch times out
        do_reset(2);
        use_uart = 1'b0; busy_force = 1'b0;
        req = 4'b0100; req_data = 32'h00C3_0000;
        wait_grant("rot_a", 10, 1'b1, g);
        check("rot_first", g, 4'b0100);
        wait_idle("rot_a", 20);
        req = 4'b0101; req_data = 32'h0077_0066;
        wait_grant("rot_b", 10, 1'b1, g);
        check("rot_wrap", g, 4'b0001);
        wait_idle("rot_b", 20);
        wait_grant("rot_c", 10, 1'b1, g);
        check("rot_next", g, 4'b0100);
        wait_idle("rot_c", 20);

        // Timeout distance from START_WAIT entry
        req = 4'b0010; req_data = 32'h0000_5500;
        wait_grant("tmo", 10, 1'b1, g);
        check("tmo_grant", g, 4'b0010);
        n = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(); n++;
            if (timeout_err) seen = 1'b1;
        end
        check("tmo_seen",   seen, 1);
        check("tmo_cycles", n, TMO);
        check("tmo_idle",   idle, 1);
        step();
        check("tmo_pulse_1cyc", timeout_err, 0);

        // External busy blocks the launch
        busy_force = 1'b1;
        req = 4'b1000; req_data = 32'h9900_0000;
        n = 0;
        repeat (20) begin
            step();
            if (grant != 0) n++;
        end
        check("busy_no_grant", n, 0);
        busy_force = 1'b0;
        step();
        check("busy_release_grant", grant, 4'b1000);
        req = '0;
        wait_idle("busy", 20);

        // Reset in the middle of a frame
        use_uart = 1'b1;
        req = 4'b0001; req_data = 32'h0000_005A;
        wait_grant("mid", 10, 1'b1, g);
        repeat (5) step();
        check("mid_busy_state", idle, 0);
        do_reset(2);
        check("mid_rst_grant",  grant,     0);
        check("mid_rst_start",  tx_start,  0);
        check("mid_rst_data",   tx_data,   0);
        check("mid_rst_id",     active_id, 0);
        check("mid_rst_idle",   idle,      1);
        req = 4'b0010; req_data = 32'h0000_3C00;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 1200 && !seen; i++) begin
            step(); n++;
            if (tx_start) seen = 1'b1;
        end
        check("mid_launch_seen", seen, 1);
        check("mid_launch_busy", last_b, 0);
        check("mid_waited_frame", n > 900, 1);
        req = '0;
        wait_idle("mid", 1200);

        // Randomized traffic with a random busy pattern and rare resets
        use_uart = 1'b0; busy_force = 1'b0;
        do_reset(2);
        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 5) == 0) busy_force = ~busy_force;
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (e_grant[i]) req[i] = ($urandom_range(0, 3) == 0);
                    else if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters; it is fixed at 4 for this revision.
REQ-002 The block SHALL have parameter START_TIMEOUT, default 8, giving the max cycles to wait for tx_busy to rise after a launch.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 The block SHALL have port req  input  4  per-requester request; bit i high means byte pending on requester i.
REQ-006 The block SHALL have port req_data  input  32  packed request bytes; requester i occupies bits [8i+7:8i].
REQ-007 The block SHALL have port grant  output  4  one-hot single-cycle acceptance pulse to the requester whose byte was launched.
REQ-008 The block SHALL have port tx_data  output  8  byte presented to the shared UART transmitter data_in.
REQ-009 The block SHALL have port tx_start  output  1  single-cycle start pulse to the shared UART transmitter.
REQ-010 The block SHALL have port tx_busy  input  1  busy flag from the shared UART transmitter.
REQ-011 The block SHALL have port active_id  output  2  index of the requester that owns the transmitter in the current or last transfer.
REQ-012 The block SHALL have port idle  output  1  high when the FSM is in IDLE.
REQ-013 The block SHALL have port timeout_err  output  1  single-cycle pulse when tx_busy fails to rise within START_TIMEOUT cycles.

Function
REQ-014 The block SHALL implement FSM states IDLE, START_WAIT and BUSY; all outputs SHALL be registered.
REQ-015 In IDLE, if tx_busy=0 and req is non-zero, the block SHALL select one requester i by round-robin at that clock edge.
REQ-016 On that edge the block SHALL register tx_data=req_data[i], tx_start=1, grant[i]=1 and active_id=i, and enter START_WAIT.
REQ-017 tx_start and grant SHALL be high for exactly one cycle per transfer, and SHALL be coincident.
REQ-018 Round-robin: a priority pointer (reset 0) SHALL give first priority to requester ptr, then ptr+1, ptr+2 and ptr+3 mod 4; after a grant to requester i, ptr SHALL become (i+1) mod 4.
REQ-019 In IDLE with tx_busy=1, the block SHALL not launch, regardless of req, and SHALL wait for tx_busy to go low.
REQ-020 In START_WAIT: if tx_busy=1, the block SHALL go to BUSY and clear the timeout counter.
REQ-021 In START_WAIT: otherwise the block SHALL increment a 4-bit counter; when the counter reaches START_TIMEOUT, the block SHALL pulse timeout_err for 1 cycle and go to IDLE.
REQ-022 In BUSY, the block SHALL return to IDLE on the first cycle tx_busy=0.
REQ-023 The earliest next launch SHALL be on the edge after IDLE is re-entered; this gives at least 1 idle cycle between frames.
REQ-024 Requester rule: a requester SHALL hold req high and req_data stable until it sees grant; it may drop req in the cycle after grant.
REQ-025 A req deasserted before being granted SHALL be dropped without a grant or side effect.
REQ-026 req changes while in START_WAIT or BUSY SHALL not affect the current transfer.
REQ-027 Only one grant SHALL be issued per transfer; a requester still holding req after its grant SHALL be treated as a new request.
REQ-028 Minimum latency SHALL be 1 cycle from req sampled in IDLE to grant/tx_start high.

Reset
REQ-029 While rst=1, the block SHALL set: state=IDLE, ptr=0, grant=0, tx_start=0, tx_data=0x00, active_id=0, timeout_err=0, counter=0; idle SHALL read 1 on the first cycle after reset.
REQ-030 Reset mid-transfer SHALL abort tracking with no grant or tx_start issued during reset; after reset, the block SHALL obey REQ-019, so a frame still in flight SHALL finish before the next launch.

Verification
REQ-031 The bench SHALL cover single request: req=0001, req_data[7:0]=0xAA, with a uart_simple_tx/rx pair (CLKS_PER_BIT=100) -> grant=0001 for 1 cycle, tx_start 1 cycle, rx_data=0xAA with rx_valid, then idle=1.
REQ-032 The bench SHALL cover all-request fairness: req=1111 held with bytes 0x11, 0x22, 0x33, 0x44 -> grants in order 0,1,2,3,0, and the receiver sees 0x11, 0x22, 0x33, 0x44, 0x11.
REQ-033 The bench SHALL cover pointer rotation: grant to requester 2, then req=0101 -> the next grant goes to requester 0... (ptr=3 wraps to 0) -> grant=0001 before 0100.
REQ-034 The bench SHALL cover timeout: tx_busy tied 0, req=0010 -> grant=0010, then timeout_err pulses exactly 8 cycles after START_WAIT entry, and the block returns to IDLE.
REQ-035 The bench SHALL cover external busy: tx_busy forced 1 while req=1000 -> no grant; when tx_busy is released, grant=1000 occurs on the following edge.
REQ-036 The bench SHALL cover reset mid-frame: rst pulsed during BUSY -> all outputs reach their reset values, and no tx_start is issued until tx_busy reads 0.
